// File: rtl/lu_dispatch_if.sv
// Instruction issue and result return handshakes between a requester and lu_dispatch.
interface lu_dispatch_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    instr_op;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;

    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_rd;
    logic [N-1:0]  res_data;
    logic          res_err;

    // Requester side: offers instructions, consumes results.
    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready,
        input  res_valid, res_rd, res_data, res_err,
        output res_ready
    );

    // Dispatch side: accepts instructions, presents results.
    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output instr_ready,
        output res_valid, res_rd, res_data, res_err,
        input  res_ready
    );
endinterface

// File: rtl/lu_dispatch.sv
// Issue/writeback front end for the logic unit: reads operands from a small
// register file, drives the logic unit, writes its result back and returns it.
module lu_dispatch #(
    parameter  int unsigned N    = 32,
    parameter  int unsigned REGS = 8,
    localparam int unsigned AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    lu_dispatch_if.slave  bus,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data,
    output logic [N-1:0]  lu_a,
    output logic [N-1:0]  lu_b,
    output logic [4:0]    lu_s,
    input  logic [N-1:0]  lu_c
);
    localparam int unsigned OPW = 5;
    localparam logic [OPW-1:0] OP_MIN = 5'b01010;
    localparam logic [OPW-1:0] OP_MAX = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   regs_q [REGS];
    logic [N-1:0]   regs_d [REGS];
    logic [N-1:0]   lu_a_q, lu_a_d;
    logic [N-1:0]   lu_b_q, lu_b_d;
    logic [OPW-1:0] lu_s_q, lu_s_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic           legal_q, legal_d;
    logic           res_valid_q, res_valid_d;
    logic [AW-1:0]  res_rd_q, res_rd_d;
    logic [N-1:0]   res_data_q, res_data_d;
    logic           res_err_q, res_err_d;
    logic           instr_ready_c;
    logic           op_legal_c;

    assign op_legal_c = (bus.instr_op >= OP_MIN) && (bus.instr_op <= OP_MAX);

    // Next-state, register file update and handshake decode.
    always_comb begin
        state_d       = state_q;
        regs_d        = regs_q;
        lu_a_d        = lu_a_q;
        lu_b_d        = lu_b_q;
        lu_s_d        = lu_s_q;
        rd_d          = rd_q;
        legal_d       = legal_q;
        res_valid_d   = res_valid_q;
        res_rd_d      = res_rd_q;
        res_data_d    = res_data_q;
        res_err_d     = res_err_q;
        instr_ready_c = 1'b0;

        // Preload applies in every state; the EXEC writeback below overrides it.
        if (ld_valid) begin
            regs_d[ld_addr] = ld_data;
        end

        unique case (state_q)
            IDLE: begin
                // A pending load blocks issue so operand reads never race it.
                instr_ready_c = ~ld_valid;
                if (bus.instr_valid && instr_ready_c) begin
                    lu_a_d  = regs_q[bus.instr_rs1];
                    lu_b_d  = regs_q[bus.instr_rs2];
                    lu_s_d  = bus.instr_op;
                    rd_d    = bus.instr_rd;
                    legal_d = op_legal_c;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = legal_q ? lu_c : '0;
                res_err_d   = ~legal_q;
                res_rd_d    = rd_q;
                res_valid_d = 1'b1;
                if (legal_q) begin
                    regs_d[rd_q] = lu_c;
                end
                state_d = WB;
            end
            WB: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, register file and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(REGS); i++) begin
                regs_q[i] <= '0;
            end
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_s_q      <= '0;
            rd_q        <= '0;
            legal_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            lu_s_q      <= lu_s_d;
            rd_q        <= rd_d;
            legal_q     <= legal_d;
            res_valid_q <= res_valid_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.instr_ready = instr_ready_c;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_err     = res_err_q;
    assign lu_a            = lu_a_q;
    assign lu_b            = lu_b_q;
    assign lu_s            = lu_s_q;
    assign dbg_data        = regs_q[dbg_addr];
endmodule

// File: tb/tb_lu_dispatch.sv
// Self-checking bench for lu_dispatch with a behavioural logic unit on lu_*.
module tb_lu_dispatch;
    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] lu_a;
    logic [31:0] lu_b;
    logic [4:0]  lu_s;
    logic [31:0] lu_c;

    lu_dispatch_if #(.N(32), .AW(3)) bus ();

    lu_dispatch #(.N(32), .REGS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .lu_a     (lu_a),
        .lu_b     (lu_b),
        .lu_s     (lu_s),
        .lu_c     (lu_c)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Logic unit behaviour; illegal opcodes deliberately yield nonzero junk.
    function automatic logic [31:0] lu_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            5'b01010: return a & b;
            5'b01011: return a | b;
            5'b01100: return a ^ b;
            5'b01101: return ~(a & b);
            5'b01110: return ~(a | b);
            5'b01111: return ~(a ^ b);
            5'b10000: return ~a;
            5'b10001: return (~a) + 32'd1;
            default:  return a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        return (int'(op) >= 10) && (int'(op) <= 17);
    endfunction

    assign lu_c = lu_ref(lu_s, lu_a, lu_b);

    int          n_checks;
    int          n_fail;
    logic [31:0] m [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dbg_chk(input string nm, input logic [2:0] a, input logic [31:0] e);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, e);
    endtask

    // Waits (bounded) until the offered instruction would be accepted at the next edge.
    task automatic wait_ready(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        #1;
        while (!bus.instr_ready && n < 8) begin
            tick();
            #1;
            n++;
        end
        if (!bus.instr_ready) begin
            ok = 1'b0;
            chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
        end
    endtask

    // One full instruction: issue, optional load during EXEC, stall, drain.
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input int stall, input logic [31:0] exp_d,
                         input logic exp_e, input logic [31:0] exp_a, input logic [31:0] exp_b,
                         input logic xl, input logic [2:0] la, input logic [31:0] ldd);
        bit ok;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
        bus.instr_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            bus.instr_valid = 1'b0;
            return;
        end
        tick();
        bus.instr_valid = 1'b0;
        if (xl) begin
            ld_valid = 1'b1;
            ld_addr  = la;
            ld_data  = ldd;
        end
        chk("exec_no_valid", 32'(bus.res_valid), 32'd0);
        chk("exec_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        ld_valid = 1'b0;
        chk("wb_valid", 32'(bus.res_valid), 32'd1);
        chk("wb_data", bus.res_data, exp_d);
        chk("wb_rd", 32'(bus.res_rd), 32'(rd));
        chk("wb_err", 32'(bus.res_err), 32'(exp_e));
        chk("lu_a", lu_a, exp_a);
        chk("lu_b", lu_b, exp_b);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(bus.res_valid), 32'd1);
            chk("stall_data", bus.res_data, exp_d);
            chk("stall_rd", 32'(bus.res_rd), 32'(rd));
            chk("stall_ready", 32'(bus.instr_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("drain_valid", 32'(bus.res_valid), 32'd0);
        chk("drain_ready", 32'(bus.instr_ready), 32'd1);
        chk("lu_s_hold", 32'(lu_s), 32'(op));
    endtask

    // Load while in IDLE, optionally racing an offered instruction that must be refused.
    task automatic idle_load(input logic [2:0] a, input logic [31:0] d, input bit with_instr);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        if (with_instr) begin
            bus.instr_op    = 5'b01010;
            bus.instr_rd    = 3'($urandom_range(0, 7));
            bus.instr_rs1   = 3'($urandom_range(0, 7));
            bus.instr_rs2   = 3'($urandom_range(0, 7));
            bus.instr_valid = 1'b1;
            #1;
            chk("load_blocks_ready", 32'(bus.instr_ready), 32'd0);
        end
        tick();
        ld_valid        = 1'b0;
        bus.instr_valid = 1'b0;
        m[a]            = d;
        #1;
        chk("load_no_accept", 32'(bus.instr_ready), 32'd1);
        dbg_chk("load_dbg", a, d);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        int          stall;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit          ok;
        int          acc;
        int          got;
        int          acc_cyc [2];
        logic [4:0]  op;
        logic [2:0]  rd, rs1, rs2, la;
        logic [31:0] a, b, e, ldd;
        logic        xl;
        int          stall;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{5'b01010, 3'd3, 3'd1, 3'd2, 0, 32'hF000_F000, 1'b0};
        vecs[1] = '{5'b00000, 3'd3, 3'd1, 3'd2, 1, 32'h0000_0000, 1'b1};
        vecs[2] = '{5'b01010, 3'd6, 3'd2, 3'd2, 0, 32'hFF00_FF00, 1'b0};
        vecs[3] = '{5'b01100, 3'd7, 3'd3, 3'd1, 5, 32'h00F0_00F0, 1'b0};
        vecs[4] = '{5'b10010, 3'd1, 3'd1, 3'd2, 0, 32'h0000_0000, 1'b1};
        vecs[5] = '{5'b11111, 3'd2, 3'd2, 3'd1, 2, 32'h0000_0000, 1'b1};
        vecs[6] = '{5'b10000, 3'd0, 3'd2, 3'd0, 0, 32'h00FF_00FF, 1'b0};
        vecs[7] = '{5'b01001, 3'd3, 3'd1, 3'd2, 0, 32'h0000_0000, 1'b1};

        rst_n           = 1'b0;
        ld_valid        = 1'b0;
        ld_addr         = '0;
        ld_data         = '0;
        dbg_addr        = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.res_ready   = 1'b0;
        for (int i = 0; i < 8; i++) m[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_res_rd", 32'(bus.res_rd), 32'd0);
        chk("rst_res_err", 32'(bus.res_err), 32'd0);
        chk("rst_lu_a", lu_a, 32'd0);
        chk("rst_lu_s", 32'(lu_s), 32'd0);
        rst_n = 1'b1;
        dbg_chk("rst_dbg0", 3'd0, 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);

        idle_load(3'd1, 32'hF0F0_F0F0, 1'b0);
        idle_load(3'd2, 32'hFF00_FF00, 1'b0);

        // Table-driven single instructions
        for (int v = 0; v < 8; v++) begin
            a = m[vecs[v].rs1];
            b = m[vecs[v].rs2];
            issue(vecs[v].op, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].stall,
                  vecs[v].exp_d, vecs[v].exp_e, a, b, 1'b0, 3'd0, 32'd0);
            if (!vecs[v].exp_e) m[vecs[v].rd] = vecs[v].exp_d;
            dbg_chk("vec_dbg_rd", vecs[v].rd, m[vecs[v].rd]);
        end
        dbg_chk("illegal_keeps_r3", 3'd3, 32'hF000_F000);

        // Back-to-back negate then OR with res_ready held high
        bus.instr_op    = 5'b10001;
        bus.instr_rd    = 3'd4;
        bus.instr_rs1   = 3'd1;
        bus.instr_rs2   = 3'd0;
        bus.instr_valid = 1'b1;
        bus.res_ready   = 1'b1;
        acc = 0;
        got = 0;
        for (int k = 0; k < 20 && got < 2; k++) begin
            #1;
            if (bus.res_valid) begin
                chk("b2b_data", bus.res_data, (got == 0) ? 32'h0F0F_0F10 : 32'hFFF0_FFF0);
                got++;
            end
            if (bus.instr_valid && bus.instr_ready && acc < 2) begin
                acc_cyc[acc] = k;
                acc++;
            end
            tick();
            if (acc == 1) begin
                bus.instr_op  = 5'b01011;
                bus.instr_rd  = 3'd5;
                bus.instr_rs1 = 3'd2;
                bus.instr_rs2 = 3'd1;
            end else if (acc == 2) begin
                bus.instr_valid = 1'b0;
            end
        end
        bus.instr_valid = 1'b0;
        bus.res_ready   = 1'b0;
        chk("b2b_results", 32'(got), 32'd2);
        chk("b2b_accepts", 32'(acc), 32'd2);
        if (acc == 2) chk("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        m[4] = 32'h0F0F_0F10;
        m[5] = 32'hFFF0_FFF0;
        dbg_chk("b2b_r4", 3'd4, m[4]);
        dbg_chk("b2b_r5", 3'd5, m[5]);

        // Load colliding with the EXEC writeback, then load racing an issue in IDLE
        issue(5'b01100, 3'd6, 3'd1, 3'd2, 0, 32'h0FF0_0FF0, 1'b0, m[1], m[2],
              1'b1, 3'd6, 32'h1234_5678);
        m[6] = 32'h0FF0_0FF0;
        dbg_chk("collide_r6", 3'd6, 32'h0FF0_0FF0);
        issue(5'b01011, 3'd0, 3'd1, 3'd1, 0, 32'hF0F0_F0F0, 1'b0, m[1], m[1],
              1'b1, 3'd7, 32'hCAFE_0001);
        m[7] = 32'hCAFE_0001;
        m[0] = 32'hF0F0_F0F0;
        dbg_chk("exec_load_other", 3'd7, 32'hCAFE_0001);
        idle_load(3'd7, 32'hA5A5_A5A5, 1'b1);

        // Asynchronous reset during EXEC
        bus.instr_op    = 5'b01010;
        bus.instr_rd    = 3'd5;
        bus.instr_rs1   = 3'd1;
        bus.instr_rs2   = 3'd2;
        bus.instr_valid = 1'b1;
        wait_ready(ok);
        tick();
        bus.instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lu_a", lu_a, 32'd0);
        chk("arst_lu_b", lu_b, 32'd0);
        chk("arst_lu_s", 32'(lu_s), 32'd0);
        chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("arst_res_data", bus.res_data, 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("arst_dbg", dbg_data, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m[i] = '0;
        #1;
        chk("arst_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        chk("arst_no_result", 32'(bus.res_valid), 32'd0);
        dbg_chk("arst_no_wb", 3'd5, 32'd0);

        // Randomised traffic against the register-file model
        for (int i = 0; i < 8; i++) idle_load(3'(i), $urandom, ($urandom_range(0, 1) == 1));
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(10, 17));
            else                           op = 5'($urandom_range(0, 31));
            rd    = 3'($urandom_range(0, 7));
            rs1   = 3'($urandom_range(0, 7));
            rs2   = 3'($urandom_range(0, 7));
            stall = $urandom_range(0, 3);
            xl    = ($urandom_range(0, 3) == 0);
            la    = ($urandom_range(0, 1) == 1) ? rd : 3'($urandom_range(0, 7));
            ldd   = $urandom;
            a     = m[rs1];
            b     = m[rs2];
            e     = is_legal(op) ? lu_ref(op, a, b) : 32'd0;
            issue(op, rd, rs1, rs2, stall, e, !is_legal(op), a, b, xl, la, ldd);
            if (xl) m[la] = ldd;
            if (is_legal(op)) m[rd] = e;
            dbg_chk("rand_dbg_rd", rd, m[rd]);
            if (xl) dbg_chk("rand_dbg_ld", la, m[la]);
            if ($urandom_range(0, 5) == 0) begin
                idle_load(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 1) == 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lu_dispatch.md
Name: lu_dispatch

Overview:
Issue/writeback front end for the logic unit. Accepts logic instructions over a valid/ready handshake and reads two source operands from an internal register file. Drives registered a/b/s to the logic unit, captures its combinational result, writes it back and presents it on a result handshake. This block is the initiator side; the logic unit is the responder.

Parameters:
N, 32, datapath width; must equal the logic unit width.
REGS, 8, register file depth; the address width AW = clog2(REGS).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
instr_valid  input  1  instruction offered
instr_ready  output  1  instruction accepted when valid&ready
instr_op  input  5  logic-unit opcode
instr_rd  input  AW  destination register
instr_rs1  input  AW  source register for a
instr_rs2  input  AW  source register for b
ld_valid  input  1  register preload strobe
ld_addr  input  AW  preload address
ld_data  input  N  preload data
dbg_addr  input  AW  debug read address
dbg_data  output  N  regfile[dbg_addr], combinational
lu_a  output  N  operand a to the logic unit
lu_b  output  N  operand b to the logic unit
lu_s  output  5  opcode to the logic unit
lu_c  input  N  logic unit result
res_valid  output  1  result available
res_ready  input  1  result consumed when valid&ready
res_rd  output  AW  destination of the presented result
res_data  output  N  result value
res_err  output  1  1 = illegal opcode, no writeback

Behaviour:
- Reset (async, rst_n=0) clears the state to IDLE and clears all register file entries to 0. It also clears lu_a, lu_b, lu_s, res_valid, res_rd, res_data and res_err to 0. Reset mid-operation abandons the in-flight instruction with no writeback.
- Legal opcodes: 5'b01010 through 5'b10001 inclusive. All others are illegal.
- FSM states:
  - IDLE: instr_ready = ~ld_valid. On accept:
    - lu_a <= reg[rs1], lu_b <= reg[rs2], lu_s <= op.
    - Latch rd and a legal flag.
    - Go to EXEC.
  - EXEC: one cycle. lu_c is valid from the registered lu_a/lu_b/lu_s.
    - res_data <= legal ? lu_c : 0.
    - res_err <= ~legal; res_rd <= rd; res_valid <= 1.
    - If legal, reg[rd] <= lu_c.
    - Go to WB.
  - WB: hold res_valid, res_rd, res_data and res_err stable until res_ready=1. That cycle, clear res_valid and go to IDLE.
- instr_ready = 0 in EXEC and WB. Throughput is at most one instruction per 3 cycles; a stalled WB extends this.
- Latency: accept at edge T gives res_valid=1 after edge T+2. The register file holds the new value from T+2.
- lu_a, lu_b and lu_s keep their last values after the instruction completes. They are not cleared.
- Preload: ld_valid writes reg[ld_addr] <= ld_data at the clock edge, in any state.
  - In IDLE, ld_valid forces instr_ready=0, so no operand read races a load.
  - Collision in EXEC (ld_addr == rd, legal op): the writeback wins and the load is dropped.
- rs1 == rs2 is legal; both operands read the same entry. rd may equal rs1 or rs2; operands were captured in IDLE, so there is no hazard.
- dbg_data is a purely combinational read of the current register file contents.
- Widths: no arithmetic is performed here. The negate opcode's carry-out is discarded by the logic unit; this block stores lu_c unmodified at N bits.

Test Plan:
The bench instantiates the team logic unit (N=32) on the lu_* ports.
1. Load r1=0xF0F0F0F0 and r2=0xFF00FF00. Issue AND (01010), rd=3, rs1=1, rs2=2, accepted at T -> res_valid high after T+2; res_data=0xF000F000, res_rd=3, res_err=0; dbg_addr=3 reads 0xF000F000.
2. Using r1 from test 1, issue 10001 (negate) rd=4, rs1=1, then OR (01011) rd=5, rs1=2, rs2=1 back to back with res_ready=1 -> r4=0x0F0F0F10, r5=0xFFF0FFF0; the second instruction is accepted no earlier than 3 cycles after the first.
3. Issue illegal opcode 5'b00000 with rd=3 -> res_valid with res_err=1 and res_data=0; r3 stays 0xF000F000.
4. Hold res_ready=0 for 5 cycles after res_valid rises -> res_valid, res_data and res_rd stay stable and instr_ready=0 throughout; on res_ready=1 there is one transfer, then IDLE, then instr_ready=1.
5. In the EXEC cycle of XOR (01100) rd=6, rs1=1, rs2=2, assert ld_valid with ld_addr=6 and ld_data=0x12345678 -> r6=0x0FF00FF0 (writeback wins). A load in IDLE while instr_valid=1 forces instr_ready=0.
6. Assert rst_n=0 asynchronously mid-EXEC -> outputs and dbg_data go to 0 immediately; no writeback occurs; after release instr_ready=1.
